adder_run_controller: RTL

//  Wishbone-mapped sequencer for the instrumented adder project inside wrapped_project.

---
 rtl/adder_run_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adder_run_controller.sv
// Wishbone-mapped sequencer for the instrumented adder: holds the operands,
// runs one timed ring-oscillator window and captures the count and the sum.
module adder_run_controller #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDER_W    = 8,
    parameter int          COUNT_W    = 32,
    parameter int          SETTLE_CYC = 4,
    parameter int          SYNC_CYC   = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [ADDER_W-1:0] adder_a_o,
    output logic [ADDER_W-1:0] adder_b_o,
    input  logic [ADDER_W:0]   adder_sum_i,
    output logic               ring_en_o,
    output logic               count_rst_o,
    input  logic [COUNT_W-1:0] ring_count_i,
    output logic               busy_o,
    output logic               irq_o
);

    typedef enum logic [2:0] {IDLE, SETTLE, RUN, STOP, CAPTURE} state_t;

    state_t             state;
    logic [31:0]        cnt;
    logic [31:0]        window;
    logic [COUNT_W-1:0] result;
    logic [ADDER_W:0]   sum;
    logic               irq_en;
    logic               done;

    logic        req, wr, rd, ctrl_wr;
    logic [7:0]  offset;
    logic [31:0] byte_mask, oper_word, oper_next, window_next, rd_data, run_load;

    // The ack itself blocks a second request, giving the 2-cycle minimum access.
    assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign rd      = req & ~wbs_we_i;
    assign offset  = wbs_adr_i[7:0];
    assign ctrl_wr = wr && (offset == 8'h00);

    assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign oper_next   = (oper_word & ~byte_mask) | (wbs_dat_i & byte_mask);
    assign window_next = (window & ~byte_mask) | (wbs_dat_i & byte_mask);

    // RUN counts down from WINDOW-1; a zero window still runs one cycle.
    assign run_load = (window == 32'd0) ? 32'd0 : window - 32'd1;

    assign irq_o = done & irq_en;

    // Pack operands into their register layout and select read data.
    always_comb begin
        oper_word = '0;
        oper_word[ADDER_W-1:0]  = adder_a_o;
        oper_word[ADDER_W+15:16] = adder_b_o;
        rd_data = '0;
        case (offset)
            8'h00:   rd_data = {29'd0, done, irq_en, busy_o};
            8'h04:   rd_data = oper_word;
            8'h08:   rd_data = window;
            8'h0C:   rd_data = 32'(result);
            8'h10:   rd_data = 32'(sum);
            default: rd_data = '0;
        endcase
    end

    // Single-cycle ack with read data registered alongside it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rd_data : 32'd0;
        end
    end

    // Software-writable configuration; operands and window freeze while busy.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adder_a_o <= '0;
            adder_b_o <= '0;
            window    <= 32'd16;
            irq_en    <= 1'b0;
        end else if (wr) begin
            case (offset)
                8'h00: irq_en <= wbs_dat_i[1];
                8'h04: if (!busy_o) begin
                    adder_a_o <= oper_next[ADDER_W-1:0];
                    adder_b_o <= oper_next[ADDER_W+15:16];
                end
                8'h08: if (!busy_o) window <= window_next;
                default: ;
            endcase
        end
    end

    // Measurement sequencer with registered ring/counter/busy controls.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            ring_en_o   <= 1'b0;
            count_rst_o <= 1'b1;
            busy_o      <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            sum         <= '0;
        end else begin
            // Capture below is later in the block, so a set on CAPTURE wins.
            if (ctrl_wr && wbs_dat_i[2]) done <= 1'b0;
            case (state)
                IDLE: if (ctrl_wr && wbs_dat_i[0]) begin
                    state  <= SETTLE;
                    cnt    <= 32'(SETTLE_CYC - 1);
                    busy_o <= 1'b1;
                    done   <= 1'b0;
                end
                SETTLE: if (cnt == 32'd0) begin
                    state       <= RUN;
                    cnt         <= run_load;
                    ring_en_o   <= 1'b1;
                    count_rst_o <= 1'b0;
                end else cnt <= cnt - 32'd1;
                RUN: if (cnt == 32'd0) begin
                    state     <= STOP;
                    cnt       <= 32'(SYNC_CYC - 1);
                    ring_en_o <= 1'b0;
                end else cnt <= cnt - 32'd1;
                STOP: if (cnt == 32'd0) state <= CAPTURE;
                      else cnt <= cnt - 32'd1;
                CAPTURE: begin
                    result      <= ring_count_i;
                    sum         <= adder_sum_i;
                    done        <= 1'b1;
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    count_rst_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
